timer_mmss_multi: RTL and testbench

//  Parametrised BCD mm:ss timer, successor of the fixed 1-digit-minute countdown timer.

---
 rtl/timer_mmss_multi.sv | 188 ++++++++++++++++++
 tb/tb_timer_mmss_multi.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_mmss_multi.sv
`default_nettype none
// ============================================================================
//  Module      : timer_mmss_multi
//  Description : BCD mm:ss timer with N minute digits, seconds prescaler,
//                up/down counting, start/stop, auto-reload and done pulse.
//                Digits are keyed in serially and the count drives the
//                7-segment display path directly.
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_mmss_multi #(
    parameter int MIN_DIGITS = 2,
    parameter int TICK_DIV   = 100
) (
    input  logic                    clock,
    input  logic                    clr,
    input  logic [3:0]              data,
    input  logic                    load,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    up,
    input  logic                    reload_en,
    output logic [3:0]              sec_ones,
    output logic [3:0]              sec_tens,
    output logic [4*MIN_DIGITS-1:0] mins,
    output logic                    zero,
    output logic                    running,
    output logic                    done
);

    localparam int c_MW = 4 * MIN_DIGITS;
    localparam int c_CW = c_MW + 8;
    localparam int c_PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_PW-1:0] c_PRESC_TOP = c_PW'(TICK_DIV - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_PAUSE = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    // Count and preset are held as {minutes, sec_tens, sec_ones}.
    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic            r_running;
    logic            r_done;
    logic [c_CW-1:0] r_cnt;
    logic [c_CW-1:0] r_preset;
    logic [c_PW-1:0] r_presc;

    logic [c_CW-1:0] w_shift;
    logic [c_CW-1:0] w_step;
    logic [c_CW-1:0] w_start_val;
    logic [c_CW-1:0] w_target;
    logic            w_tick;
    logic            w_at_tgt;
    logic            w_hit;
    logic            w_preset_zero;

    assign w_start_val   = up ? '0 : r_preset;
    assign w_target      = up ? r_preset : '0;
    assign w_tick        = (r_presc == c_PRESC_TOP);
    assign w_at_tgt      = (r_cnt == w_target);
    assign w_hit         = (w_step == w_target);
    assign w_preset_zero = (r_preset == '0);

    // Keypad entry: shift the display left one digit, clamping to valid BCD.
    always_comb begin
        w_shift      = {r_cnt[c_CW-5:0], 4'd0};
        w_shift[3:0] = (data > 4'd9) ? 4'd9 : data;
        w_shift[7:4] = (r_cnt[3:0] > 4'd5) ? 4'd5 : r_cnt[3:0];
    end

    // One BCD step up or down; seconds tens wraps at 5, every other digit at 9.
    always_comb begin : p_step
        logic       w_cy;
        logic [3:0] w_lim;
        w_step = r_cnt;
        w_cy   = 1'b1;
        w_lim  = 4'd9;
        for (int i = 0; i < MIN_DIGITS + 2; i++) begin
            w_lim = (i == 1) ? 4'd5 : 4'd9;
            if (w_cy) begin
                if (up) begin
                    if (r_cnt[4*i +: 4] >= w_lim) begin
                        w_step[4*i +: 4] = 4'd0;
                    end else begin
                        w_step[4*i +: 4] = r_cnt[4*i +: 4] + 4'd1;
                        w_cy             = 1'b0;
                    end
                end else begin
                    if (r_cnt[4*i +: 4] == 4'd0) begin
                        w_step[4*i +: 4] = w_lim;
                    end else begin
                        w_step[4*i +: 4] = r_cnt[4*i +: 4] - 4'd1;
                        w_cy             = 1'b0;
                    end
                end
            end
        end
    end

    // Next-state logic; stop always beats start.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE, c_DONE: begin
                if (start) begin
                    w_state_nxt = w_preset_zero ? c_DONE : c_RUN;
                end else if (load) begin
                    w_state_nxt = c_IDLE;
                end
            end
            c_RUN: begin
                if (stop) begin
                    w_state_nxt = c_PAUSE;
                end else if (w_tick && !w_at_tgt && w_hit && !reload_en) begin
                    w_state_nxt = c_DONE;
                end
            end
            c_PAUSE: begin
                if (start && !stop) begin
                    w_state_nxt = c_RUN;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // State register with registered running flag.
    always_ff @(posedge clock or posedge clr) begin
        if (clr) begin
            r_state   <= c_IDLE;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_running <= (w_state_nxt == c_RUN);
        end
    end

    // Count, preset and prescaler datapath; done is a single-cycle strobe.
    always_ff @(posedge clock or posedge clr) begin
        if (clr) begin
            r_cnt    <= '0;
            r_preset <= '0;
            r_presc  <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (start) begin
                        r_cnt   <= w_start_val;
                        r_presc <= '0;
                        r_done  <= w_preset_zero;
                    end else if (load) begin
                        r_cnt    <= w_shift;
                        r_preset <= w_shift;
                    end
                end
                c_RUN: begin
                    if (!stop) begin
                        if (w_tick) begin
                            r_presc <= '0;
                            // Terminal value is shown for a full tick before reloading.
                            if (w_at_tgt) begin
                                r_cnt <= w_start_val;
                            end else begin
                                r_cnt  <= w_step;
                                r_done <= w_hit;
                            end
                        end else begin
                            r_presc <= r_presc + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign sec_ones = r_cnt[3:0];
    assign sec_tens = r_cnt[7:4];
    assign mins     = r_cnt[c_CW-1:8];
    assign zero     = (r_cnt == '0);
    assign running  = r_running;
    assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_timer_mmss_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_timer_mmss_multi
//  Description : Scoreboard bench for timer_mmss_multi (2 minute digits,
//                4 cycles per tick). Directed stimulus queues expected
//                display snapshots and done pulses; a monitor checks them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_mmss_multi;

    localparam int MD = 2;
    localparam int TD = 4;

    logic          clk = 1'b0;
    logic          clr = 1'b0;
    logic [3:0]    data = 4'd0;
    logic          load = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          up = 1'b0;
    logic          reload_en = 1'b0;
    logic [3:0]    sec_ones;
    logic [3:0]    sec_tens;
    logic [4*MD-1:0] mins;
    logic          zero;
    logic          running;
    logic          done;

    timer_mmss_multi #(.MIN_DIGITS(MD), .TICK_DIV(TD)) u_dut (
        .clock(clk), .clr(clr), .data(data), .load(load), .start(start),
        .stop(stop), .up(up), .reload_en(reload_en), .sec_ones(sec_ones),
        .sec_tens(sec_tens), .mins(mins), .zero(zero), .running(running),
        .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] m;
        logic [3:0] t;
        logic [3:0] o;
        logic       run;
        logic       dn;
    } snap_t;

    typedef struct {
        string       name;
        logic [15:0] val;
    } dexp_t;

    snap_t snap_q[$];
    dexp_t done_q[$];
    int    n_chk  = 0;
    int    n_fail = 0;

    // Monitor: compare queued snapshots and every done pulse on the falling edge.
    always @(negedge clk) begin : p_mon
        snap_t e;
        dexp_t d;
        logic  ez;
        if (snap_q.size() > 0) begin
            e  = snap_q.pop_front();
            ez = (e.m == 8'h00) && (e.t == 4'h0) && (e.o == 4'h0);
            n_chk++;
            if ({mins, sec_tens, sec_ones, zero, running, done} !==
                {e.m, e.t, e.o, ez, e.run, e.dn}) begin
                n_fail++;
                $display("FAIL %s: got %h:%h%h zero=%b running=%b done=%b, want %h:%h%h zero=%b running=%b done=%b",
                         e.name, mins, sec_tens, sec_ones, zero, running, done,
                         e.m, e.t, e.o, ez, e.run, e.dn);
            end
        end
        if (done === 1'b1) begin
            n_chk++;
            if (done_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: got done=1 at %h:%h%h, want no pulse",
                         mins, sec_tens, sec_ones);
            end else begin
                d = done_q.pop_front();
                if ({mins, sec_tens, sec_ones} !== d.val) begin
                    n_fail++;
                    $display("FAIL %s: got done at %h, want done at %h",
                             d.name, {mins, sec_tens, sec_ones}, d.val);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [7:0] m, input logic [3:0] t,
                       input logic [3:0] o, input logic r, input logic d);
        snap_t s;
        s.name = nm; s.m = m; s.t = t; s.o = o; s.run = r; s.dn = d;
        snap_q.push_back(s);
        @(negedge clk);
        #1;
    endtask

    task automatic exp_done(input string nm, input logic [15:0] v);
        dexp_t d;
        d.name = nm; d.val = v;
        done_q.push_back(d);
    endtask

    task automatic ld(input logic [3:0] v);
        data = v; load = 1'b1;
        cyc(1);
        load = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic clr_pulse();
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
    endtask

    // Directed stimulus.
    initial begin : p_stim
        int k;
        clr = 1'b1;
        cyc(2);
        clr = 1'b0;
        chk("reset", 8'h00, 4'h0, 4'h0, 1'b0, 1'b0);

        // Entry clamps and top-digit discard.
        ld(4'd9);  chk("load_9", 8'h00, 4'h0, 4'h9, 1'b0, 1'b0);
        ld(4'd9);  chk("tens_clamp", 8'h00, 4'h5, 4'h9, 1'b0, 1'b0);
        ld(4'd12); chk("data_clamp", 8'h05, 4'h5, 4'h9, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) ld(4'(i));
        chk("top_discard", 8'h23, 4'h4, 4'h5, 1'b0, 1'b0);

        // Down count from 02:06 to 00:00.
        ld(4'd0); ld(4'd2); ld(4'd0); ld(4'd6);
        chk("preset_206", 8'h02, 4'h0, 4'h6, 1'b0, 1'b0);
        exp_done("done_down", 16'h0000);
        go();
        chk("down_start", 8'h02, 4'h0, 4'h6, 1'b1, 1'b0);
        cyc(3); chk("down_pre_tick", 8'h02, 4'h0, 4'h6, 1'b1, 1'b0);
        cyc(1); chk("down_tick1", 8'h02, 4'h0, 4'h5, 1'b1, 1'b0);
        cyc(20); chk("down_200", 8'h02, 4'h0, 4'h0, 1'b1, 1'b0);
        cyc(4); chk("down_borrow_159", 8'h01, 4'h5, 4'h9, 1'b1, 1'b0);
        k = 0;
        for (int i = 1; i <= 600; i++) begin
            cyc(1);
            if (done === 1'b1) begin
                k = i;
                break;
            end
        end
        n_chk++;
        if (k != 476) begin
            n_fail++;
            $display("FAIL down_latency: got %0d cycles, want 476", k);
        end
        chk("down_done", 8'h00, 4'h0, 4'h0, 1'b0, 1'b1);
        cyc(1); chk("down_done_clear", 8'h00, 4'h0, 4'h0, 1'b0, 1'b0);
        cyc(8); chk("down_hold", 8'h00, 4'h0, 4'h0, 1'b0, 1'b0);

        // Up count with auto-reload, preset 00:03.
        up = 1'b1; reload_en = 1'b1;
        ld(4'd0); ld(4'd3);
        chk("up_preset", 8'h00, 4'h0, 4'h3, 1'b0, 1'b0);
        exp_done("done_up1", 16'h0003);
        exp_done("done_up2", 16'h0003);
        go();
        chk("up_start", 8'h00, 4'h0, 4'h0, 1'b1, 1'b0);
        cyc(4); chk("up_001", 8'h00, 4'h0, 4'h1, 1'b1, 1'b0);
        cyc(4); chk("up_002", 8'h00, 4'h0, 4'h2, 1'b1, 1'b0);
        cyc(4); chk("up_003_done", 8'h00, 4'h0, 4'h3, 1'b1, 1'b1);
        cyc(1); chk("up_003_hold", 8'h00, 4'h0, 4'h3, 1'b1, 1'b0);
        cyc(3); chk("up_reload", 8'h00, 4'h0, 4'h0, 1'b1, 1'b0);
        cyc(4); chk("up_again_001", 8'h00, 4'h0, 4'h1, 1'b1, 1'b0);
        cyc(8); chk("up_again_done", 8'h00, 4'h0, 4'h3, 1'b1, 1'b1);
        stop = 1'b1; cyc(1); stop = 1'b0;
        chk("up_stopped", 8'h00, 4'h0, 4'h3, 1'b0, 1'b0);

        // Pause/resume keeps prescaler phase; stop beats start.
        clr_pulse();
        up = 1'b0; reload_en = 1'b0;
        ld(4'd4); ld(4'd2);
        chk("pause_preset", 8'h00, 4'h4, 4'h2, 1'b0, 1'b0);
        go();
        chk("pause_run", 8'h00, 4'h4, 4'h2, 1'b1, 1'b0);
        cyc(8); chk("pause_040", 8'h00, 4'h4, 4'h0, 1'b1, 1'b0);
        cyc(2);
        stop = 1'b1; cyc(1); stop = 1'b0;
        chk("paused", 8'h00, 4'h4, 4'h0, 1'b0, 1'b0);
        ld(4'd7); chk("load_ignored", 8'h00, 4'h4, 4'h0, 1'b0, 1'b0);
        cyc(20); chk("pause_frozen", 8'h00, 4'h4, 4'h0, 1'b0, 1'b0);
        go();
        chk("resume", 8'h00, 4'h4, 4'h0, 1'b1, 1'b0);
        cyc(1); chk("resume_phase", 8'h00, 4'h4, 4'h0, 1'b1, 1'b0);
        cyc(1); chk("resume_tick", 8'h00, 4'h3, 4'h9, 1'b1, 1'b0);
        stop = 1'b1; start = 1'b1; cyc(1); stop = 1'b0; start = 1'b0;
        chk("stop_prio", 8'h00, 4'h3, 4'h9, 1'b0, 1'b0);
        cyc(8); chk("stop_prio_hold", 8'h00, 4'h3, 4'h9, 1'b0, 1'b0);

        // Asynchronous clear mid-count, then start with preset zero.
        go();
        cyc(2);
        clr = 1'b1;
        chk("clr_async", 8'h00, 4'h0, 4'h0, 1'b0, 1'b0);
        cyc(1);
        clr = 1'b0;
        exp_done("done_zero_preset", 16'h0000);
        go();
        chk("zero_preset_done", 8'h00, 4'h0, 4'h0, 1'b0, 1'b1);
        cyc(1); chk("zero_preset_clear", 8'h00, 4'h0, 4'h0, 1'b0, 1'b0);
        cyc(8); chk("zero_preset_hold", 8'h00, 4'h0, 4'h0, 1'b0, 1'b0);

        // Minute borrow chains.
        ld(4'd1); ld(4'd0); ld(4'd0); ld(4'd0);
        chk("preset_1000", 8'h10, 4'h0, 4'h0, 1'b0, 1'b0);
        go();
        cyc(4); chk("borrow_959", 8'h09, 4'h5, 4'h9, 1'b1, 1'b0);
        clr_pulse();
        ld(4'd1); ld(4'd0); ld(4'd0);
        chk("preset_100", 8'h01, 4'h0, 4'h0, 1'b0, 1'b0);
        go();
        cyc(4); chk("borrow_059", 8'h00, 4'h5, 4'h9, 1'b1, 1'b0);
        clr_pulse();
        cyc(4);

        n_chk++;
        if (done_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_done: got %0d pulses outstanding, want 0", done_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
